nanorv32_apb_bridge: RTL and testbench

APB master bridge between the nanorv32 peripheral data port and the APB peripheral bus; it feeds APB slaves such as the CPU control register block. It accepts one CPU load/store at a time and decodes the slave index from the address. It runs a standard two-phase APB transfer (setup, access), waits for `pready`, and returns read data and an error flag to the core. Accesses to unmapped slaves and slaves that time out complete with an error instead of hanging the core.

---
 rtl/nanorv32_apb_pkg.sv | 15 +
 rtl/apb_resp_mux.sv | 29 ++
 rtl/nanorv32_apb_bridge.sv | 136 +++++++++++++
 tb/tb_nanorv32_apb_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nanorv32_apb_pkg.sv
// Shared types and widths for the nanorv32 APB master bridge.
package nanorv32_apb_pkg;

    localparam int APB_AW   = 12;
    localparam int APB_DW   = 32;
    localparam int APB_IDXW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } apb_state_e;

endpackage

// File: rtl/apb_resp_mux.sv
// Selects prdata/pready/pslverr of the addressed slave; out-of-range index yields zeros.
module apb_resp_mux
    import nanorv32_apb_pkg::*;
#(
    parameter int NSLAVE = 4
) (
    input  logic [APB_IDXW-1:0]      i_idx,
    input  logic [APB_DW*NSLAVE-1:0] i_prdata,
    input  logic [NSLAVE-1:0]        i_pready,
    input  logic [NSLAVE-1:0]        i_pslverr,
    output logic [APB_DW-1:0]        o_rdata,
    output logic                     o_ready,
    output logic                     o_slverr
);

    always_comb begin
        o_rdata  = '0;
        o_ready  = 1'b0;
        o_slverr = 1'b0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (i_idx == APB_IDXW'(i)) begin
                o_rdata  = i_prdata[APB_DW*i +: APB_DW];
                o_ready  = i_pready[i];
                o_slverr = i_pslverr[i];
            end
        end
    end

endmodule

// File: rtl/nanorv32_apb_bridge.sv
// APB3 master bridge: one CPU load/store at a time, slave decode, wait states and timeout abort.
module nanorv32_apb_bridge
    import nanorv32_apb_pkg::*;
#(
    parameter int NSLAVE  = 4,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_apb,
    input  logic                     rst_apb,
    input  logic                     cpu_apb_req,
    input  logic [31:0]              cpu_apb_addr,
    input  logic                     cpu_apb_we,
    input  logic [31:0]              cpu_apb_wdata,
    output logic                     apb_cpu_done,
    output logic [31:0]              apb_cpu_rdata,
    output logic                     apb_cpu_err,
    output logic [NSLAVE-1:0]        apb_psel,
    output logic [APB_AW-1:0]        apb_paddr,
    output logic                     apb_penable,
    output logic                     apb_pwrite,
    output logic [APB_DW-1:0]        apb_pwdata,
    input  logic [APB_DW*NSLAVE-1:0] apb_prdata,
    input  logic [NSLAVE-1:0]        apb_pready,
    input  logic [NSLAVE-1:0]        apb_pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e          r_state;
    apb_state_e          w_state_nxt;
    logic [APB_IDXW-1:0] r_idx;
    logic [APB_AW-1:0]   r_addr;
    logic                r_we;
    logic [APB_DW-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_cnt;
    logic [APB_DW-1:0]   r_rdata;
    logic                r_err;

    logic [APB_IDXW-1:0] w_idx;
    logic                w_idx_ok;
    logic                w_tmo;
    logic [APB_DW-1:0]   w_rdata;
    logic                w_ready;
    logic                w_slverr;
    logic                w_unused;

    assign w_idx    = cpu_apb_addr[SEL_LSB +: APB_IDXW];
    assign w_idx_ok = (int'(w_idx) < NSLAVE);
    assign w_tmo    = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_unused = ^cpu_apb_addr;

    apb_resp_mux #(.NSLAVE(NSLAVE)) u_resp_mux (
        .i_idx     (r_idx),
        .i_prdata  (apb_prdata),
        .i_pready  (apb_pready),
        .i_pslverr (apb_pslverr),
        .o_rdata   (w_rdata),
        .o_ready   (w_ready),
        .o_slverr  (w_slverr)
    );

    always_ff @(posedge clk_apb) begin
        if (rst_apb) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (cpu_apb_req) w_state_nxt = w_idx_ok ? ST_SETUP : ST_DONE;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_ready || w_tmo) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Response registers are loaded only on entry to DONE and cleared on exit,
    // so rdata/err read as zero whenever done is low.
    always_ff @(posedge clk_apb) begin
        if (rst_apb) begin
            r_idx   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cpu_apb_req) begin
                        if (w_idx_ok) begin
                            r_idx   <= w_idx;
                            r_addr  <= {cpu_apb_addr[APB_AW-1:2], 2'b00};
                            r_we    <= cpu_apb_we;
                            r_wdata <= cpu_apb_wdata;
                            r_cnt   <= '0;
                        end else begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_ready) begin
                        r_rdata <= r_we ? '0 : w_rdata;
                        r_err   <= w_slverr;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign apb_psel      = (r_state == ST_SETUP || r_state == ST_ACCESS)
                           ? (NSLAVE'(1) << r_idx) : '0;
    assign apb_penable   = (r_state == ST_ACCESS);
    assign apb_paddr     = r_addr;
    assign apb_pwrite    = r_we;
    assign apb_pwdata    = r_wdata;
    assign apb_cpu_done  = (r_state == ST_DONE);
    assign apb_cpu_rdata = r_rdata;
    assign apb_cpu_err   = r_err;

endmodule

// File: tb/tb_nanorv32_apb_bridge.sv
// Scoreboard bench for nanorv32_apb_bridge with a per-slave wait-state model.
module tb_nanorv32_apb_bridge;

    localparam int NS = 4;
    localparam int TO = 8;

    logic           clk_apb = 1'b0;
    logic           rst_apb;
    logic           cpu_apb_req;
    logic [31:0]    cpu_apb_addr;
    logic           cpu_apb_we;
    logic [31:0]    cpu_apb_wdata;
    logic           apb_cpu_done;
    logic [31:0]    apb_cpu_rdata;
    logic           apb_cpu_err;
    logic [NS-1:0]  apb_psel;
    logic [11:0]    apb_paddr;
    logic           apb_penable;
    logic           apb_pwrite;
    logic [31:0]    apb_pwdata;
    logic [32*NS-1:0] apb_prdata;
    logic [NS-1:0]  apb_pready;
    logic [NS-1:0]  apb_pslverr;

    nanorv32_apb_bridge #(.NSLAVE(NS), .SEL_LSB(12), .TIMEOUT(TO)) dut (
        .clk_apb(clk_apb), .rst_apb(rst_apb),
        .cpu_apb_req(cpu_apb_req), .cpu_apb_addr(cpu_apb_addr),
        .cpu_apb_we(cpu_apb_we), .cpu_apb_wdata(cpu_apb_wdata),
        .apb_cpu_done(apb_cpu_done), .apb_cpu_rdata(apb_cpu_rdata), .apb_cpu_err(apb_cpu_err),
        .apb_psel(apb_psel), .apb_paddr(apb_paddr), .apb_penable(apb_penable),
        .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
    );

    always #5 clk_apb = ~clk_apb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk_apb) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave model: pready rises after slv_wait ACCESS cycles; huge wait = hung slave
    int          slv_wait [NS];
    logic [31:0] slv_rdata[NS];
    logic        slv_err  [NS];
    int          wcnt     [NS];
    logic [31:0] wr_data  [NS];

    always_comb begin
        apb_prdata  = '0;
        apb_pready  = '0;
        apb_pslverr = '0;
        for (int i = 0; i < NS; i++) begin
            apb_prdata[32*i +: 32] = slv_rdata[i];
            apb_pready[i]  = apb_psel[i] & apb_penable & (wcnt[i] >= slv_wait[i]);
            apb_pslverr[i] = slv_err[i];
        end
    end

    always @(posedge clk_apb) begin
        for (int i = 0; i < NS; i++) begin
            wcnt[i] <= (apb_psel[i] && apb_penable) ? wcnt[i] + 1 : 0;
            if (apb_psel[i] && !apb_penable && apb_pwrite) wr_data[i] <= apb_pwdata;
        end
    end

    // Bus monitor
    int          setup_cyc, access_cyc, pwd_bad, paddr_bad, hot_bad;
    logic [NS-1:0] psel_seen;
    logic [31:0] exp_pwdata;
    logic [11:0] exp_paddr;

    always @(negedge clk_apb) begin
        if (|apb_psel) begin
            psel_seen = psel_seen | apb_psel;
            if (!$onehot(apb_psel)) hot_bad++;
            if (apb_penable) access_cyc++; else setup_cyc++;
            if (apb_pwdata !== exp_pwdata) pwd_bad++;
            if (apb_paddr !== exp_paddr) paddr_bad++;
        end
    end

    // Scoreboard monitor
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    always @(negedge clk_apb) begin
        if (apb_cpu_done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_rdata", apb_cpu_rdata, e.rdata);
                chk("done_err", 32'(apb_cpu_err), 32'(e.err));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (!rst_apb) begin
            chk("idle_resp_zero", {apb_cpu_rdata[31:1], apb_cpu_rdata[0] | apb_cpu_err}, 32'h0);
        end
    end

    task automatic do_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [31:0] erd, input logic eerr, input int lat,
                           input int esetup, input int eaccess, input logic [NS-1:0] epsel);
        exp_t e;
        bit got;
        @(posedge clk_apb); #1;
        setup_cyc = 0; access_cyc = 0; pwd_bad = 0; paddr_bad = 0; hot_bad = 0; psel_seen = '0;
        exp_pwdata = wdata;
        exp_paddr  = {addr[11:2], 2'b00};
        e.rdata = erd; e.err = eerr; e.cyc = cyc + lat;
        q.push_back(e);
        cpu_apb_addr = addr; cpu_apb_we = we; cpu_apb_wdata = wdata; cpu_apb_req = 1'b1;
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(posedge clk_apb); #1;
            if (apb_cpu_done) got = 1;
        end
        cpu_apb_req = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done within 50 cycles");
            q.delete();
        end
        chk("setup_cycles", 32'(setup_cyc), 32'(esetup));
        chk("access_cycles", 32'(access_cyc), 32'(eaccess));
        chk("psel_seen", 32'(psel_seen), 32'(epsel));
        chk("pwdata_stable", 32'(pwd_bad), 32'h0);
        chk("paddr_stable", 32'(paddr_bad), 32'h0);
        chk("psel_onehot", 32'(hot_bad), 32'h0);
    endtask

    initial begin
        int t0;
        int ndone;
        exp_t e;
        rst_apb = 1'b1; cpu_apb_req = 1'b0; cpu_apb_addr = '0; cpu_apb_we = 1'b0; cpu_apb_wdata = '0;
        for (int i = 0; i < NS; i++) begin
            slv_wait[i] = 0; slv_rdata[i] = '0; slv_err[i] = 1'b0; wr_data[i] = '0;
        end
        exp_pwdata = '0; exp_paddr = '0; psel_seen = '0;
        setup_cyc = 0; access_cyc = 0; pwd_bad = 0; paddr_bad = 0; hot_bad = 0;
        repeat (2) @(posedge clk_apb);
        #1;
        chk("rst_psel", 32'(apb_psel), 32'h0);
        chk("rst_penable", 32'(apb_penable), 32'h0);
        chk("rst_pwrite", 32'(apb_pwrite), 32'h0);
        chk("rst_paddr", 32'(apb_paddr), 32'h0);
        chk("rst_pwdata", apb_pwdata, 32'h0);
        chk("rst_done", 32'(apb_cpu_done), 32'h0);
        chk("rst_rdata", apb_cpu_rdata, 32'h0);
        chk("rst_err", 32'(apb_cpu_err), 32'h0);
        rst_apb = 1'b0;

        // zero-wait write to slave 0
        do_xfer(32'h0000_0000, 1'b1, 32'h0000_A5A5, 32'h0, 1'b0, 3, 1, 1, 4'b0001);
        chk("slave0_wdata", wr_data[0], 32'h0000_A5A5);

        // read slave 2 with 3 wait states
        slv_wait[2] = 3; slv_rdata[2] = 32'h1234_5678;
        do_xfer(32'h0000_2004, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 6, 1, 4, 4'b0100);

        // unmapped index 5
        do_xfer(32'h0000_5000, 1'b0, 32'h0, 32'h0, 1'b1, 1, 0, 0, 4'b0000);

        // hung slave 3 times out after TO access cycles
        slv_wait[3] = 1000; slv_rdata[3] = 32'hFFFF_FFFF;
        do_xfer(32'h0000_3010, 1'b0, 32'h0, 32'h0, 1'b1, TO + 2, 1, TO, 4'b1000);

        // slave error on read (data still returned) and on write (data 0), unaligned addr
        slv_err[1] = 1'b1; slv_rdata[1] = 32'hDEAD_BEEF;
        do_xfer(32'h0000_100B, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b1, 3, 1, 1, 4'b0010);
        do_xfer(32'h0000_1020, 1'b1, 32'h1111_2222, 32'h0, 1'b1, 3, 1, 1, 4'b0010);
        chk("slave1_wdata", wr_data[1], 32'h1111_2222);

        // pready in the same cycle as the timeout limit: normal completion
        slv_wait[0] = TO - 1; slv_rdata[0] = 32'hCAFE_0007;
        do_xfer(32'h0000_0FFC, 1'b0, 32'h0, 32'hCAFE_0007, 1'b0, TO + 2, 1, TO, 4'b0001);

        // reset during ACCESS: bus dropped, no done
        slv_wait[2] = 3;
        @(posedge clk_apb); #1;
        cpu_apb_addr = 32'h0000_2008; cpu_apb_we = 1'b1; cpu_apb_wdata = 32'h5555_AAAA; cpu_apb_req = 1'b1;
        for (int n = 0; n < 20 && !apb_penable; n++) begin
            @(posedge clk_apb); #1;
        end
        chk("pre_rst_penable", 32'(apb_penable), 32'h1);
        rst_apb = 1'b1;
        @(posedge clk_apb); #1;
        cpu_apb_req = 1'b0;
        chk("midrst_psel", 32'(apb_psel), 32'h0);
        chk("midrst_penable", 32'(apb_penable), 32'h0);
        chk("midrst_pwrite", 32'(apb_pwrite), 32'h0);
        chk("midrst_paddr", 32'(apb_paddr), 32'h0);
        chk("midrst_pwdata", apb_pwdata, 32'h0);
        chk("midrst_done", 32'(apb_cpu_done), 32'h0);
        @(posedge clk_apb); #1;
        rst_apb = 1'b0;
        repeat (5) @(posedge clk_apb);

        // back-to-back with req held high: dones 4 cycles apart
        slv_wait[2] = 0; slv_rdata[2] = 32'h0BB0_0BB0;
        @(posedge clk_apb); #1;
        setup_cyc = 0; access_cyc = 0; psel_seen = '0;
        exp_pwdata = 32'h0; exp_paddr = 12'h000;
        t0 = cyc;
        e.rdata = 32'h0BB0_0BB0; e.err = 1'b0;
        e.cyc = t0 + 3; q.push_back(e);
        e.cyc = t0 + 7; q.push_back(e);
        cpu_apb_addr = 32'h0000_2000; cpu_apb_we = 1'b0; cpu_apb_wdata = 32'h0; cpu_apb_req = 1'b1;
        ndone = 0;
        for (int n = 0; n < 40 && ndone < 2; n++) begin
            @(posedge clk_apb); #1;
            if (apb_cpu_done) ndone++;
        end
        cpu_apb_req = 1'b0;
        chk("b2b_done_count", 32'(ndone), 32'd2);
        chk("b2b_setup_cycles", 32'(setup_cyc), 32'd2);
        chk("b2b_access_cycles", 32'(access_cyc), 32'd2);

        repeat (5) @(posedge clk_apb);
        #1;
        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
